serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around the single-bit half/full-adder cell plus a carry flop.

---
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// Latency: operands accepted at edge 0, out_valid rises after edge WIDTH; one add per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional SERIAL_ADDER_SUB_EN adds a-b.

// Single-bit half adder.
module serial_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// Single-bit full adder built from two half adders.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  serial_adder_ha u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  serial_adder_ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  // Generate and propagate carries can never both be set, so OR is exact.
  assign co = c0 | c1;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction reuses the adder: a + ~b + 1, so the carry-in seeds the +1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  assign b_load = b;
  assign c_load = 1'b0;
`endif

  // The one arithmetic cell, fed from the LSBs of the operand shifters.
  serial_adder_fa u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (c_q),
    .s  (s_bit),
    .co (c_nxt)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = s_bit;
  end

  // Operands are only taken while idle; no overlap between adds.
  assign in_ready = (state == IDLE);

  // Control FSM and datapath registers; outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b_load;
            c_q   <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          c_q <= c_nxt;
          sum <= sum_shift;
          if (cnt == LAST_BIT) begin
            // Counter parks at WIDTH-1; it is reloaded on the next accept.
            carry     <= c_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: drives three serial_adder instances (WIDTH 8, 13, 1) against an arithmetic model.
// Latency: checks out_valid exactly WIDTH edges after accept.
// Backpressure: holds out_ready low for a few cycles and checks the result stays put.
module tb_serial_adder;
  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic        sub_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic [2:0]  iv;

  logic        ir8, ov8, c8, bz8;
  logic [7:0]  s8;
  logic        ir13, ov13, c13, bz13;
  logic [12:0] s13;
  logic        ir1, ov1, c1, bz1;
  logic [0:0]  s1;

  int          sel;
  logic        o_ir, o_ov, o_c, o_bz;
  logic [31:0] o_sum;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8),
    .a(a_d[7:0]), .b(b_d[7:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_d),
`endif
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .carry(c8), .busy(bz8)
  );

  serial_adder #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir13),
    .a(a_d[12:0]), .b(b_d[12:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_d),
`endif
    .out_valid(ov13), .out_ready(out_ready), .sum(s13), .carry(c13), .busy(bz13)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir1),
    .a(a_d[0:0]), .b(b_d[0:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_d),
`endif
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .carry(c1), .busy(bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // View of whichever instance the current operation targets.
  always_comb begin
    o_ir  = ir8;
    o_ov  = ov8;
    o_c   = c8;
    o_bz  = bz8;
    o_sum = {24'd0, s8};
    case (sel)
      1: begin o_ir = ir13; o_ov = ov13; o_c = c13; o_bz = bz13; o_sum = {19'd0, s13}; end
      2: begin o_ir = ir1;  o_ov = ov1;  o_c = c1;  o_bz = bz1;  o_sum = {31'd0, s1};  end
      default: ;
    endcase
  end

  function automatic int wid(input int idx);
    case (idx)
      1:       return 13;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete add/sub transaction with an optional out_ready stall of 'hold' cycles.
  task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input int hold, input string tag);
    int               w;
    int               n;
    longint unsigned  mask, ea, eb, es;
    logic             ec;
    logic             bad_run;
    logic             bad_hold;
    logic [31:0]      h_sum;
    logic             h_c;
    w    = wid(idx);
    mask = (64'd1 << w) - 64'd1;
    ea   = longint'(av) & mask;
    eb   = longint'(bv) & mask;
    if (sv) begin
      es = (ea - eb) & mask;
      ec = (ea >= eb);
    end else begin
      es = (ea + eb) & mask;
      ec = ((ea + eb) >> w) != 0;
    end

    @(negedge clk);
    sel       = idx;
    a_d       = av;
    b_d       = bv;
    sub_d     = sv;
    out_ready = (hold == 0);
    iv[idx]   = 1'b1;
    #1;
    chk({tag, "_idle_rdy"}, o_ir, 1);
    @(posedge clk);
    @(negedge clk);
    iv[idx] = 1'b0;
    a_d     = $urandom;
    b_d     = $urandom;
    n       = 0;
    bad_run = 1'b0;
    while (!o_ov && n < 100) begin
      if (o_ir || !o_bz) bad_run = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, w);
    chk({tag, "_run_flags"}, bad_run, 0);

    h_sum    = o_sum;
    h_c      = o_c;
    bad_hold = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (!o_ov || o_ir || o_sum !== h_sum || o_c !== h_c) bad_hold = 1'b1;
      @(negedge clk);
    end
    if (hold > 0) chk({tag, "_hold"}, bad_hold, 0);
    out_ready = 1'b1;
    chk({tag, "_valid"}, o_ov, 1);
    chk({tag, "_sum"}, o_sum, es);
    chk({tag, "_carry"}, o_c, ec);
    @(negedge clk);
    chk({tag, "_post_valid"}, o_ov, 0);
    chk({tag, "_post_rdy"}, o_ir, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    sub_d     = 1'b0;
    a_d       = '0;
    b_d       = '0;
    iv        = '0;
    sel       = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_busy", bz8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_carry", c8, 0);
    chk("rst_w1_rdy", ir1, 1);
    rst_n = 1'b1;

    // Directed cases
    run_op(0, 32'h00, 32'h00, 1'b0, 0, "zero");
    run_op(0, 32'hFF, 32'h01, 1'b0, 0, "ff_p1");
    run_op(0, 32'hA5, 32'h5A, 1'b0, 0, "a5_5a");
    run_op(0, 32'h80, 32'h80, 1'b0, 5, "bp_80");

    // Reset in the middle of an add
    @(negedge clk);
    sel     = 0;
    a_d     = 32'h0F;
    b_d     = 32'h01;
    sub_d   = 1'b0;
    iv[0]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", bz8, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_busy", bz8, 0);
    chk("mid_rst_sum", s8, 0);
    chk("mid_rst_carry", c8, 0);
    chk("mid_rst_rdy", ir8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'h03, 32'h04, 1'b0, 0, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
    run_op(0, 32'h05, 32'h07, 1'b1, 0, "sub_5_7");
    run_op(0, 32'h07, 32'h05, 1'b1, 0, "sub_7_5");
    run_op(1, 32'h0000, 32'h0000, 1'b1, 0, "sub13_eq");
`endif

    // WIDTH=1 corner cases
    run_op(2, 32'd1, 32'd1, 1'b0, 0, "w1_11");
    run_op(2, 32'd1, 32'd0, 1'b0, 1, "w1_10");
    run_op(2, 32'd0, 32'd0, 1'b0, 0, "w1_00");

    // Random vectors at WIDTH=8 and 13
    for (int idx = 0; idx < 2; idx++) begin
      for (int i = 0; i < 1000; i++) begin
        logic sv;
        sv = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sv = $urandom_range(0, 1) == 1;
`endif
        k = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        run_op(idx, $urandom, $urandom, sv, k, (idx == 0) ? "rnd8" : "rnd13");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
